div_rem_radix: RTL and testbench

Parametrised, iterative divide/remainder unit for the core's M-extension execution path, in the same slot as the existing unsigned divider. It retires `RADIX_BITS` quotient bits per cycle, handles signed and unsigned operands, and returns RISC-V divide-by-zero and overflow results through a fast path. It keeps the core's `order`/`accepted`/`done` handshake and supports back-to-back issue.

---
 rtl/divrem_pkg.sv | 17 +
 rtl/divrem_radix_step.sv | 51 +++++
 rtl/div_rem_radix.sv | 136 +++++++++++++
 tb/tb_div_rem_radix.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divrem_pkg.sv
// Shared definitions for the iterative radix divide/remainder unit.
// FSM state encoding and RISC-V special-case result constants.
package divrem_pkg;

  localparam int LEN_WORD = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } divrem_state_e;

  localparam logic [LEN_WORD-1:0] DIV_ZERO_Q = '1;
  localparam logic [LEN_WORD-1:0] SIGNED_MIN = 32'h8000_0000;

endpackage

// File: rtl/divrem_radix_step.sv
// One restoring-division digit: shifts in RADIX_BITS dividend bits and
// subtracts the largest multiple of the divisor that fits.
module divrem_radix_step #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic [WIDTH+RADIX_BITS-1:0] pr,
  input  logic [WIDTH-1:0]            dvs,
  input  logic [RADIX_BITS-1:0]       din,
  output logic [WIDTH+RADIX_BITS-1:0] pr_next,
  output logic [RADIX_BITS-1:0]       k
);

  localparam int PW = WIDTH + RADIX_BITS;
  localparam int K  = 1 << RADIX_BITS;

  // Constant multiple built only from shifted copies of the divisor.
  function automatic logic [PW-1:0] mul_k(
    input logic [WIDTH-1:0] d,
    input int               c
  );
    logic [PW-1:0] acc;
    acc = '0;
    for (int b = 0; b < RADIX_BITS; b++) begin
      if (c[b]) acc = acc + (PW'(d) << b);
    end
    return acc;
  endfunction

  logic [PW-1:0] sh;
  logic [PW-1:0] mult [K];

  assign sh = (pr << RADIX_BITS) | PW'(din);

  for (genvar i = 0; i < K; i++) begin : g_mult
    assign mult[i] = mul_k(dvs, i);
  end

  // Multiples ascend, so the last fitting one is the largest digit.
  always_comb begin
    k       = '0;
    pr_next = sh;
    for (int i = 0; i < K; i++) begin
      if (mult[i] <= sh) begin
        k       = RADIX_BITS'(i);
        pr_next = sh - mult[i];
      end
    end
  end

endmodule

// File: rtl/div_rem_radix.sv
// Iterative signed/unsigned divide-remainder, RADIX_BITS quotient bits
// per cycle, with divide-by-zero and overflow handled at accept.
module div_rem_radix
  import divrem_pkg::*;
#(
  parameter int WIDTH      = LEN_WORD,
  parameter int RADIX_BITS = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             order,
  output logic             accepted,
  output logic             done,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             unsig,
  input  logic             rem_flag,
  output logic [WIDTH-1:0] rd
);

  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = WIDTH + RADIX_BITS;

  localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES_W = '1;

  divrem_state_e   state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo;
  logic [PW-1:0]   pr;
  logic            q_neg;
  logic            r_neg;
  logic            rem_sel;

  logic             s1;
  logic             s2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic             div_zero;
  logic             ovf;
  logic [WIDTH-1:0] spec_res;
  logic [PW-1:0]    pr_next;
  logic [RADIX_BITS-1:0] k;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign accepted = order & rstn & ((state == IDLE) | (state == DONE));

  assign s1   = ~unsig & rs1[WIDTH-1];
  assign s2   = ~unsig & rs2[WIDTH-1];
  assign mag1 = s1 ? -rs1 : rs1;
  assign mag2 = s2 ? -rs2 : rs2;

  assign div_zero = (rs2 == '0);
  assign ovf      = ~unsig & (rs1 == MIN_W) & (rs2 == ONES_W);

  always_comb begin
    spec_res = '0;
    if (div_zero) spec_res = rem_flag ? rs1 : ONES_W;
    else          spec_res = rem_flag ? '0 : MIN_W;
  end

  divrem_radix_step #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_step (
    .pr      (pr),
    .dvs     (dvs),
    .din     (dvd[WIDTH-1 -: RADIX_BITS]),
    .pr_next (pr_next),
    .k       (k)
  );

  assign rem_mag = pr[WIDTH-1:0];
  assign q_fix   = q_neg ? -quo : quo;
  assign r_fix   = r_neg ? -rem_mag : rem_mag;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      quo     <= '0;
      pr      <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      rem_sel <= 1'b0;
      done    <= 1'b0;
      rd      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (accepted) begin
            rem_sel <= rem_flag;
            q_neg   <= s1 ^ s2;
            r_neg   <= s1;
            dvd     <= mag1;
            dvs     <= mag2;
            pr      <= '0;
            quo     <= '0;
            cnt     <= CW'(N - 1);
            if (div_zero | ovf) begin
              rd    <= spec_res;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          pr  <= pr_next;
          quo <= {quo[WIDTH-RADIX_BITS-1:0], k};
          dvd <= dvd << RADIX_BITS;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          rd    <= rem_sel ? r_fix : q_fix;
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_rem_radix.sv
// Directed bench for div_rem_radix: main 32/2 instance plus a
// WIDTH/RADIX_BITS sweep against a native-arithmetic reference.
module tb_div_rem_radix;

  localparam int NI = 6;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_order [NI];
  logic        s_acc   [NI];
  logic        s_done  [NI];
  logic        s_uns   [NI];
  logic        s_rem   [NI];
  logic [31:0] s_rs1   [NI];
  logic [31:0] s_rs2   [NI];
  logic [31:0] s_rd    [NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = (g < 3) ? 32 : 16;
    localparam int R = (g == 0 || g == 4) ? 2 :
                       (g == 1 || g == 3) ? 1 : 4;
    logic [W-1:0] rd_w;
    div_rem_radix #(
      .WIDTH      (W),
      .RADIX_BITS (R)
    ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .order    (s_order[g]),
      .accepted (s_acc[g]),
      .done     (s_done[g]),
      .rs1      (s_rs1[g][W-1:0]),
      .rs2      (s_rs2[g][W-1:0]),
      .unsig    (s_uns[g]),
      .rem_flag (s_rem[g]),
      .rd       (rd_w)
    );
    assign s_rd[g] = 32'(rd_w);
  end

  function automatic int inst_w(int g);
    return (g < 3) ? 32 : 16;
  endfunction

  function automatic int inst_r(int g);
    return (g == 0 || g == 4) ? 2 : (g == 1 || g == 3) ? 1 : 4;
  endfunction

  // RISC-V reference: truncating division on sign-extended 64-bit values.
  function automatic logic [31:0] ref_res(int w, logic [31:0] a,
      logic [31:0] b, bit uns, bit remf);
    longint sa, sb, q, r;
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    a = a & mask;
    b = b & mask;
    if (uns) begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end else if (w == 32) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'($signed(a[15:0]));
      sb = longint'($signed(b[15:0]));
    end
    if (sb == 0) begin
      q = -1;
      r = sa;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return 32'(remf ? r : q) & mask;
  endfunction

  task automatic issue(input int i, input logic [31:0] a,
      input logic [31:0] b, input bit uns, input bit remf,
      output bit acc, output int lat, output logic [31:0] res);
    @(negedge clk);
    s_rs1[i]   = a;
    s_rs2[i]   = b;
    s_uns[i]   = uns;
    s_rem[i]   = remf;
    s_order[i] = 1'b1;
    #1;
    acc = s_acc[i];
    @(posedge clk);
    #1;
    s_order[i] = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      if (s_done[i]) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    res = s_rd[i];
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int g = 0; g < NI; g++) begin
      s_order[g] = 1'b0;
      s_uns[g]   = 1'b0;
      s_rem[g]   = 1'b0;
      s_rs1[g]   = '0;
      s_rs2[g]   = '0;
    end
    s_order[0] = 1'b1;
    s_rs1[0]   = 32'd5;
    s_rs2[0]   = 32'd1;
    #3;
    checks++;
    if (s_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", s_done[0]);
    end
    checks++;
    if (s_rd[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd: got %h expected 0", s_rd[0]);
    end
    checks++;
    if (s_acc[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_accepted: got %b expected 0", s_acc[0]);
    end
    @(negedge clk);
    s_order[0] = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_unsigned();
    bit acc;
    int lat;
    logic [31:0] res;
    issue(0, 32'd100, 32'd7, 1'b1, 1'b0, acc, lat, res);
    checks++;
    if (acc !== 1'b1) begin
      errors++;
      $display("FAIL udiv_accept: got %b expected 1", acc);
    end
    checks++;
    if (lat != 18) begin
      errors++;
      $display("FAIL udiv_latency: got %0d expected 18", lat);
    end
    checks++;
    if (res !== 32'd14) begin
      errors++;
      $display("FAIL udiv_q: got %h expected %h", res, 32'd14);
    end
    issue(0, 32'd100, 32'd7, 1'b1, 1'b1, acc, lat, res);
    checks++;
    if (res !== 32'd2 || lat != 18) begin
      errors++;
      $display("FAIL udiv_r: got %h lat %0d expected 2 lat 18", res, lat);
    end
  endtask

  task automatic test_signed();
    bit acc;
    int lat;
    logic [31:0] res;
    issue(0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, acc, lat, res);
    checks++;
    if (res !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL sdiv_m7_2_q: got %h expected FFFFFFFD", res);
    end
    issue(0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, acc, lat, res);
    checks++;
    if (res !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sdiv_m7_2_r: got %h expected FFFFFFFF", res);
    end
    issue(0, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, acc, lat, res);
    checks++;
    if (res !== 32'd1) begin
      errors++;
      $display("FAIL sdiv_7_m2_r: got %h expected 1", res);
    end
    issue(0, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, acc, lat, res);
    checks++;
    if (res !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL sdiv_7_m2_q: got %h expected FFFFFFFD", res);
    end
  endtask

  task automatic test_special();
    bit acc;
    int lat;
    logic [31:0] res;
    issue(0, 32'h1234, 32'h0, 1'b1, 1'b0, acc, lat, res);
    checks++;
    if (res !== 32'hFFFF_FFFF || lat != 1) begin
      errors++;
      $display("FAIL divzero_q: got %h lat %0d expected FFFFFFFF lat 1",
               res, lat);
    end
    issue(0, 32'h1234, 32'h0, 1'b0, 1'b1, acc, lat, res);
    checks++;
    if (res !== 32'h1234 || lat != 1) begin
      errors++;
      $display("FAIL divzero_r: got %h lat %0d expected 1234 lat 1",
               res, lat);
    end
    issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, acc, lat, res);
    checks++;
    if (res !== 32'h8000_0000 || lat != 1) begin
      errors++;
      $display("FAIL ovf_q: got %h lat %0d expected 80000000 lat 1",
               res, lat);
    end
    issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, acc, lat, res);
    checks++;
    if (res !== 32'h0 || lat != 1) begin
      errors++;
      $display("FAIL ovf_r: got %h lat %0d expected 0 lat 1", res, lat);
    end
    issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, acc, lat, res);
    checks++;
    if (res !== 32'h8000_0000 || lat != 18) begin
      errors++;
      $display("FAIL unsigned_min_r: got %h lat %0d expected 80000000 lat 18",
               res, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int busy_acc;
    @(negedge clk);
    s_rs1[0]   = 32'd100;
    s_rs2[0]   = 32'd7;
    s_uns[0]   = 1'b1;
    s_rem[0]   = 1'b0;
    s_order[0] = 1'b1;
    #1;
    checks++;
    if (s_acc[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_accept: got %b expected 1", s_acc[0]);
    end
    @(posedge clk);
    #1;
    lat = -1;
    busy_acc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (s_done[0]) begin
        lat = c;
        break;
      end
      if (s_acc[0] !== 1'b0) busy_acc++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (lat != 18 || s_rd[0] !== 32'd14) begin
      errors++;
      $display("FAIL b2b_first: got %h lat %0d expected 0000000e lat 18",
               s_rd[0], lat);
    end
    checks++;
    if (busy_acc != 0) begin
      errors++;
      $display("FAIL b2b_busy_accept: got %0d cycles expected 0", busy_acc);
    end
    s_rs1[0] = 32'd1000;
    s_rs2[0] = 32'hFFFF_FFFD;
    s_uns[0] = 1'b0;
    #1;
    checks++;
    if (s_acc[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done_accept: got %b expected 1", s_acc[0]);
    end
    @(posedge clk);
    #1;
    s_order[0] = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (s_done[0]) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (lat != 18 || s_rd[0] !== 32'hFFFF_FEB3) begin
      errors++;
      $display("FAIL b2b_second: got %h lat %0d expected FFFFFEB3 lat 18",
               s_rd[0], lat);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    int lat;
    int spur;
    logic [31:0] res;
    @(negedge clk);
    s_rs1[0]   = 32'd1000;
    s_rs2[0]   = 32'd3;
    s_uns[0]   = 1'b1;
    s_rem[0]   = 1'b1;
    s_order[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    checks++;
    if (s_done[0] !== 1'b0 || s_rd[0] !== 32'h0 || s_acc[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got done %b rd %h acc %b expected 0 0 0",
               s_done[0], s_rd[0], s_acc[0]);
    end
    @(negedge clk);
    s_order[0] = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    spur = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (s_done[0] !== 1'b0) spur++;
    end
    checks++;
    if (spur != 0) begin
      errors++;
      $display("FAIL mid_reset_spurious: got %0d done cycles expected 0",
               spur);
    end
    issue(0, 32'd1000, 32'd3, 1'b1, 1'b1, acc, lat, res);
    checks++;
    if (res !== 32'd1 || lat != 18) begin
      errors++;
      $display("FAIL cold_start: got %h lat %0d expected 1 lat 18", res, lat);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] expv;
    bit acc;
    int lat;
    int elat;
    logic [31:0] res;
    va[0] = 32'd100;        vb[0] = 32'd7;
    va[1] = 32'hFFFF_FF9C;  vb[1] = 32'd7;
    va[2] = 32'd100;        vb[2] = 32'hFFFF_FFF9;
    va[3] = 32'hFFFF_FF9C;  vb[3] = 32'hFFFF_FFF9;
    va[4] = 32'h7FFF_8123;  vb[4] = 32'h0000_00FF;
    va[5] = $urandom;       vb[5] = $urandom | 32'h0000_0101;
    for (int g = 0; g < NI; g++) begin
      elat = inst_w(g) / inst_r(g) + 2;
      for (int v = 0; v < 6; v++) begin
        for (int m = 0; m < 4; m++) begin
          expv = ref_res(inst_w(g), va[v], vb[v], m[1], m[0]);
          issue(g, va[v], vb[v], m[1], m[0], acc, lat, res);
          checks++;
          if (lat != elat || res !== expv) begin
            errors++;
            $display("FAIL sweep_w%0d_r%0d_v%0d_m%0d: got %h lat %0d expected %h lat %0d",
                     inst_w(g), inst_r(g), v, m, res, lat, expv, elat);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
